// File: rtl/jk_cmd_driver_if.sv
// ---------------------------------------------------------------------------
// jk_cmd_driver_if
//   Groups the request handshake and the flop-bank command/feedback signals
//   of jk_cmd_driver.
//
//   Request side : in_valid, in_ready, in_target[N], in_clear
//   Flop side    : cmd[2N] (00 HOLD, 01 RESET, 10 SET, 11 TOGGLE per flop),
//                  ff_rst (sync reset to the bank), q_fb[N] (bank outputs)
//   Status       : done / err one-cycle pulses, err_mask[N] (held)
//
//   Modports:
//     slave  - the driver itself
//     master - the environment (request source plus the flop bank)
// ---------------------------------------------------------------------------
interface jk_cmd_driver_if #(
  parameter int N = 4
) ();
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_target;
  logic           in_clear;
  logic [2*N-1:0] cmd;
  logic           ff_rst;
  logic [N-1:0]   q_fb;
  logic           done;
  logic           err;
  logic [N-1:0]   err_mask;

  modport slave (
    input  in_valid, in_target, in_clear, q_fb,
    output in_ready, cmd, ff_rst, done, err, err_mask
  );

  modport master (
    output in_valid, in_target, in_clear, q_fb,
    input  in_ready, cmd, ff_rst, done, err, err_mask
  );
endinterface

// File: rtl/jk_cmd_driver.sv
// ---------------------------------------------------------------------------
// jk_cmd_driver
//   Drives a bank of N JK flops to a requested word. A request is accepted
//   in IDLE; one DRIVE cycle issues per-flop commands (or a bank reset for a
//   clear request), one CHECK cycle compares the read-back against the
//   target. A mismatch retries up to MAX_RETRY extra times, then reports err
//   with the offending bits in err_mask.
//
//   Ports:
//     clk    - clock, all logic on posedge
//     rst_n  - asynchronous active-low reset
//     bus    - jk_cmd_driver_if.slave (handshake, cmd/ff_rst, q_fb, status)
//
//   Parameters:
//     N          - number of driven flops
//     MAX_RETRY  - extra DRIVE attempts after the first mismatch
//     USE_TOGGLE - 1: changed bits get TOGGLE, 0: changed bits get SET/RESET
// ---------------------------------------------------------------------------
module jk_cmd_driver #(
  parameter int N          = 4,
  parameter int MAX_RETRY  = 3,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  jk_cmd_driver_if.slave  bus
);

  // Counter just wide enough for 0..MAX_RETRY; never narrower than one bit.
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    target_q, target_d;
  logic            clear_q, clear_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [2*N-1:0]  cmd_q, cmd_d;
  logic            ff_rst_q, ff_rst_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [N-1:0]    err_mask_q, err_mask_d;

  // Per-flop command that moves q toward t: HOLD where equal, otherwise
  // TOGGLE or a directed SET/RESET. {t, ~t} encodes SET=10 / RESET=01.
  function automatic logic [2*N-1:0] drive_cmd(input logic [N-1:0] q,
                                               input logic [N-1:0] t);
    logic [2*N-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (q[i] != t[i]) c[2*i +: 2] = USE_TOGGLE ? 2'b11 : {t[i], ~t[i]};
    end
    return c;
  endfunction

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    clear_d    = clear_q;
    retry_d    = retry_q;
    cmd_d      = '0;      // commands last exactly the DRIVE cycle
    ff_rst_d   = 1'b0;
    done_d     = 1'b0;    // status outputs are single-cycle pulses
    err_d      = 1'b0;
    err_mask_d = err_mask_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          target_d = bus.in_clear ? '0 : bus.in_target;
          clear_d  = bus.in_clear;
          retry_d  = '0;
          state_d  = S_DRIVE;
          // Commands are registered on the accept edge so they are stable
          // for the whole DRIVE cycle.
          cmd_d    = bus.in_clear ? '0 : drive_cmd(bus.q_fb, bus.in_target);
          ff_rst_d = bus.in_clear;
        end
      end

      S_DRIVE: begin
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (bus.q_fb == target_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d  = retry_q + RW'(1);
          state_d  = S_DRIVE;
          cmd_d    = clear_q ? '0 : drive_cmd(bus.q_fb, target_q);
          ff_rst_d = clear_q;
        end else begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          err_mask_d = bus.q_fb ^ target_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      clear_q    <= 1'b0;
      retry_q    <= '0;
      cmd_q      <= '0;
      ff_rst_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      clear_q    <= clear_d;
      retry_q    <= retry_d;
      cmd_q      <= cmd_d;
      ff_rst_q   <= ff_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_mask_q <= err_mask_d;
    end
  end

  assign bus.in_ready = (state_q == S_IDLE);
  assign bus.cmd      = cmd_q;
  assign bus.ff_rst   = ff_rst_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_mask = err_mask_q;

endmodule

// File: tb/tb_jk_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_jk_cmd_driver
//   Two drivers (SET/RESET policy and TOGGLE policy) share one request
//   stream; each drives its own behavioural JK flop bank which can have
//   stuck-at bits. Expected per-cycle outputs come from the request rules:
//   the bank settles to the target with stuck bits forced, a persistent
//   mismatch costs MAX_RETRY+1 attempts of two cycles each.
// ---------------------------------------------------------------------------
module tb_jk_cmd_driver;

  localparam int N  = 4;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Request stimulus, shared by both drivers.
  logic         in_valid;
  logic [N-1:0] in_target;
  logic         in_clear;

  // Flop-bank plant controls.
  logic         preload;
  logic [N-1:0] preload_val;
  logic [N-1:0] stuck0, stuck1;
  logic [N-1:0] bank [2] = '{4'h0, 4'h0};

  jk_cmd_driver_if #(.N(N)) if0 ();
  jk_cmd_driver_if #(.N(N)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_target = in_target;
  assign if0.in_clear  = in_clear;
  assign if0.q_fb      = bank[0];
  assign if1.in_valid  = in_valid;
  assign if1.in_target = in_target;
  assign if1.in_clear  = in_clear;
  assign if1.q_fb      = bank[1];

  jk_cmd_driver #(.N(N), .MAX_RETRY(MR), .USE_TOGGLE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  jk_cmd_driver #(.N(N), .MAX_RETRY(MR), .USE_TOGGLE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Uniform views of both drivers' outputs.
  logic [2*N-1:0] cmd_o  [2];
  logic           ffr_o  [2];
  logic           rdy_o  [2];
  logic           done_o [2];
  logic           err_o  [2];
  logic [N-1:0]   mask_o [2];
  assign cmd_o[0] = if0.cmd;      assign cmd_o[1] = if1.cmd;
  assign ffr_o[0] = if0.ff_rst;   assign ffr_o[1] = if1.ff_rst;
  assign rdy_o[0] = if0.in_ready; assign rdy_o[1] = if1.in_ready;
  assign done_o[0] = if0.done;    assign done_o[1] = if1.done;
  assign err_o[0] = if0.err;      assign err_o[1] = if1.err;
  assign mask_o[0] = if0.err_mask; assign mask_o[1] = if1.err_mask;

  // JK flop bank: sync reset, HOLD/RESET/SET/TOGGLE, then stuck bits win.
  function automatic logic [N-1:0] plant_next(input logic [N-1:0] q,
                                              input logic [2*N-1:0] c,
                                              input logic r);
    logic [N-1:0] v;
    if (preload) v = preload_val;
    else if (r)  v = '0;
    else begin
      v = q;
      for (int i = 0; i < N; i++) begin
        case (c[2*i +: 2])
          2'b01:   v[i] = 1'b0;
          2'b10:   v[i] = 1'b1;
          2'b11:   v[i] = ~q[i];
          default: v[i] = q[i];
        endcase
      end
    end
    return (v & ~stuck0) | stuck1;
  endfunction

  always @(posedge clk) begin
    bank[0] <= plant_next(bank[0], cmd_o[0], ffr_o[0]);
    bank[1] <= plant_next(bank[1], cmd_o[1], ffr_o[1]);
  end

  int unsigned  n_vec  = 0;
  int unsigned  n_miss = 0;
  logic [N-1:0] exp_mask = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference command word: what a flop needs to go from q to t.
  function automatic logic [2*N-1:0] ref_cmd(input logic [N-1:0] q,
                                             input logic [N-1:0] t,
                                             input bit tog);
    logic [2*N-1:0] c = '0;
    for (int i = 0; i < N; i++)
      if (q[i] !== t[i]) c[2*i +: 2] = tog ? 2'd3 : (t[i] ? 2'd2 : 2'd1);
    return c;
  endfunction

  task automatic set_bank(input logic [N-1:0] v);
    @(negedge clk);
    preload = 1'b1;
    preload_val = v;
    @(negedge clk);
    preload = 1'b0;
  endtask

  // One request with cycle-by-cycle checking of both drivers.
  task automatic run_req(input logic [N-1:0] tgt, input logic clr);
    logic [N-1:0] t, fin;
    logic [N-1:0] q0 [2];
    logic [N-1:0] qp;
    bit fail;
    int att;
    t    = clr ? '0 : tgt;
    fin  = (t & ~stuck0) | stuck1;
    fail = (fin != t);
    att  = fail ? MR + 1 : 1;
    @(negedge clk);
    in_valid = 1'b1; in_target = tgt; in_clear = clr;
    for (int d = 0; d < 2; d++) begin
      q0[d] = bank[d];
      chk($sformatf("d%0d ready_pre", d), 32'(rdy_o[d]), 32'd1);
    end
    if (fail) exp_mask = fin ^ t;
    for (int c = 1; c <= 2 * att + 1; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (c <= 2 * att) begin
          if (c % 2 == 1) begin
            qp = (c == 1) ? q0[d] : fin;
            chk($sformatf("d%0d c%0d cmd", d, c), 32'(cmd_o[d]),
                32'(clr ? '0 : ref_cmd(qp, t, d == 1)));
            chk($sformatf("d%0d c%0d ff_rst", d, c), 32'(ffr_o[d]), 32'(clr));
          end else begin
            chk($sformatf("d%0d c%0d cmd", d, c), 32'(cmd_o[d]), 32'd0);
            chk($sformatf("d%0d c%0d ff_rst", d, c), 32'(ffr_o[d]), 32'd0);
          end
          chk($sformatf("d%0d c%0d ready", d, c), 32'(rdy_o[d]), 32'd0);
          chk($sformatf("d%0d c%0d done", d, c), 32'(done_o[d]), 32'd0);
          chk($sformatf("d%0d c%0d err", d, c), 32'(err_o[d]), 32'd0);
        end else begin
          chk($sformatf("d%0d end cmd", d), 32'(cmd_o[d]), 32'd0);
          chk($sformatf("d%0d end ready", d), 32'(rdy_o[d]), 32'd1);
          chk($sformatf("d%0d end done", d), 32'(done_o[d]), 32'(!fail));
          chk($sformatf("d%0d end err", d), 32'(err_o[d]), 32'(fail));
          chk($sformatf("d%0d end err_mask", d), 32'(mask_o[d]), 32'(exp_mask));
          chk($sformatf("d%0d end bank", d), 32'(bank[d]), 32'(fin));
        end
      end
    end
  endtask

  initial begin
    logic [N-1:0] s;
    rst_n = 1'b0;
    in_valid = 1'b0; in_target = '0; in_clear = 1'b0;
    preload = 1'b0; preload_val = '0; stuck0 = '0; stuck1 = '0;

    // Reset state.
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst ready", d), 32'(rdy_o[d]), 32'd1);
      chk($sformatf("d%0d rst cmd", d), 32'(cmd_o[d]), 32'd0);
      chk($sformatf("d%0d rst ff_rst", d), 32'(ffr_o[d]), 32'd0);
      chk($sformatf("d%0d rst done", d), 32'(done_o[d]), 32'd0);
      chk($sformatf("d%0d rst err", d), 32'(err_o[d]), 32'd0);
      chk($sformatf("d%0d rst err_mask", d), 32'(mask_o[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Set/reset policy: 0000 -> 1010 gives 10_00_10_00 on driver 0.
    set_bank(4'b0000);
    run_req(4'b1010, 1'b0);
    // Toggle policy: 1100 -> 1010 gives 00_11_11_00 on driver 1.
    set_bank(4'b1100);
    run_req(4'b1010, 1'b0);
    // Clear request from 0111.
    set_bank(4'b0111);
    run_req(4'b1111, 1'b1);
    // Stuck-at-0 bit 0, target 0001: four attempts then err with mask 0001.
    stuck0 = 4'b0001;
    set_bank(4'b0000);
    run_req(4'b0001, 1'b0);
    stuck0 = '0;

    // Reset during CHECK: outputs drop at once, no done after release.
    set_bank(4'b0000);
    @(negedge clk);
    in_valid = 1'b1; in_target = 4'b1111; in_clear = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_mask = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d midrst ready", d), 32'(rdy_o[d]), 32'd1);
      chk($sformatf("d%0d midrst cmd", d), 32'(cmd_o[d]), 32'd0);
      chk($sformatf("d%0d midrst ff_rst", d), 32'(ffr_o[d]), 32'd0);
      chk($sformatf("d%0d midrst done", d), 32'(done_o[d]), 32'd0);
      chk($sformatf("d%0d midrst err", d), 32'(err_o[d]), 32'd0);
      chk($sformatf("d%0d midrst err_mask", d), 32'(mask_o[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d postrst%0d done", d, c), 32'(done_o[d]), 32'd0);
        chk($sformatf("d%0d postrst%0d ready", d, c), 32'(rdy_o[d]), 32'd1);
      end
    end

    // Back-to-back with in_valid held: accepts at E0 and E3.
    set_bank(4'b0000);
    @(negedge clk);
    in_valid = 1'b1; in_target = 4'b0011; in_clear = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) in_target = 4'b1100;
      if (c == 4) in_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d b2b%0d ready", d, c), 32'(rdy_o[d]),
            32'(c == 3 || c == 6 || c == 7));
        chk($sformatf("d%0d b2b%0d done", d, c), 32'(done_o[d]),
            32'(c == 3 || c == 6));
        if (c == 4)
          chk($sformatf("d%0d b2b cmd2", d), 32'(cmd_o[d]),
              32'(ref_cmd(4'b0011, 4'b1100, d == 1)));
      end
    end
    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d b2b bank", d), 32'(bank[d]), 32'h0000000c);

    // Randomized requests, occasional stuck bits and clears.
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) begin
        s = 4'($urandom_range(1, 15));
        stuck1 = s & 4'($urandom);
        stuck0 = s & ~stuck1;
      end else begin
        stuck0 = '0;
        stuck1 = '0;
      end
      if ($urandom_range(0, 1) == 1) set_bank(4'($urandom_range(0, 15)));
      else @(negedge clk);
      run_req(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
